// File: rtl/diff_ddr_tx_framer4.sv
// Transmit word framer for a 4:1 diff DDR serializer (CLKDIV domain).
// Bytes arrive over valid/ready and leave as nibbles, low nibble first.
// Each frame is prefixed by SYNC_WORD, gaps carry IDLE_WORD, and a
// training request inserts a burst of TRAIN_LENGTH TRAIN_WORDs.
//
// state | meaning
// IDLE  | sending IDLE_WORD, watching for train request or tx_valid
// TRAIN | sending TRAIN_WORD burst, train_cnt words still to go
// SYNC  | SYNC_WORD on the wire, first byte taken at its word boundary
// DATA  | payload byte on the wire, next byte or frame end at boundary
module diff_ddr_tx_framer4 #(
  parameter logic [7:0] TRAIN_WORD   = 8'h5C,
  parameter logic [7:0] SYNC_WORD    = 8'hB8,
  parameter logic [7:0] IDLE_WORD    = 8'h00,
  parameter int         TRAIN_LENGTH = 64
) (
  input  logic       clk,
  input  logic       clk__enable,
  input  logic       reset_n,
  input  logic       train_req,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [3:0] data,
  output logic       training,
  output logic       underrun
);

  typedef enum logic [1:0] {IDLE, TRAIN, SYNC, DATA} state_t;

  // Burst counter is loaded with the number of words left after the first.
  localparam logic [7:0] TRAIN_LAST = 8'(TRAIN_LENGTH - 1);

  state_t     state, state_nxt;
  logic       phase;
  logic       last_taken, last_nxt;
  logic       train_pend, pend_nxt;
  logic [7:0] train_cnt, cnt_nxt;
  logic [3:0] hi_q, hi_nxt;
  logic [3:0] data_nxt;
  logic       training_nxt, underrun_nxt;
  logic [7:0] word;

  // Byte is taken only in the second nibble cycle of a SYNC/DATA word.
  assign tx_ready = clk__enable & phase & ((state == SYNC) | (state == DATA)) & ~last_taken;

  // Registered state and outputs, frozen while the clock enable is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      phase      <= 1'b0;
      last_taken <= 1'b0;
      train_pend <= 1'b0;
      train_cnt  <= 8'd0;
      hi_q       <= IDLE_WORD[7:4];
      data       <= IDLE_WORD[3:0];
      training   <= 1'b0;
      underrun   <= 1'b0;
    end else if (clk__enable) begin
      state      <= state_nxt;
      phase      <= ~phase;
      last_taken <= last_nxt;
      train_pend <= pend_nxt;
      train_cnt  <= cnt_nxt;
      hi_q       <= hi_nxt;
      data       <= data_nxt;
      training   <= training_nxt;
      underrun   <= underrun_nxt;
    end
  end

  // Next-word selection at each word boundary; high nibble otherwise.
  always_comb begin
    state_nxt    = state;
    last_nxt     = last_taken;
    cnt_nxt      = train_cnt;
    hi_nxt       = hi_q;
    data_nxt     = hi_q;
    training_nxt = training;
    underrun_nxt = 1'b0;
    pend_nxt     = train_pend;
    word         = IDLE_WORD;

    if (train_req && (state != TRAIN))
      pend_nxt = 1'b1;

    if (phase) begin
      training_nxt = 1'b0;
      case (state)
        IDLE: begin
          if (train_pend) begin
            word         = TRAIN_WORD;
            state_nxt    = TRAIN;
            cnt_nxt      = TRAIN_LAST;
            pend_nxt     = 1'b0;
            training_nxt = 1'b1;
          end else if (tx_valid) begin
            word      = SYNC_WORD;
            state_nxt = SYNC;
          end
        end
        TRAIN: begin
          if (train_cnt != 8'd0) begin
            word         = TRAIN_WORD;
            cnt_nxt      = train_cnt - 8'd1;
            training_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
        SYNC, DATA: begin
          if (last_taken) begin
            state_nxt = IDLE;
            last_nxt  = 1'b0;
          end else if (tx_valid) begin
            word      = tx_data;
            state_nxt = DATA;
            last_nxt  = tx_last;
          end else begin
            state_nxt    = IDLE;
            underrun_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
      data_nxt = word[3:0];
      hi_nxt   = word[7:4];
    end
  end

endmodule

// File: tb/tb_diff_ddr_tx_framer4.sv
// Randomized bench for diff_ddr_tx_framer4 against a word-level reference model.
module tb_diff_ddr_tx_framer4;

  localparam int         TL      = 4;
  localparam logic [7:0] TRAIN_W = 8'h5C;
  localparam logic [7:0] SYNC_W  = 8'hB8;
  localparam logic [7:0] IDLE_W  = 8'h00;

  logic       clk = 1'b0;
  logic       clk__enable, reset_n, train_req, tx_valid, tx_last;
  logic [7:0] tx_data;
  logic       tx_ready, training, underrun;
  logic [3:0] data;

  int checks = 0;
  int failures = 0;

  diff_ddr_tx_framer4 #(.TRAIN_WORD(TRAIN_W), .SYNC_WORD(SYNC_W), .IDLE_WORD(IDLE_W),
                        .TRAIN_LENGTH(TL)) dut (
    .clk(clk), .clk__enable(clk__enable), .reset_n(reset_n), .train_req(train_req),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
    .data(data), .training(training), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 training burst, 2 frame open.
  bit         m_phase, m_last, m_pend, m_train, m_und;
  int         m_mode, m_left;
  logic [3:0] m_data;
  logic [3:0] m_hi[$];

  function automatic void model_reset();
    m_phase = 0; m_last = 0; m_pend = 0; m_train = 0; m_und = 0;
    m_mode = 0; m_left = 0; m_data = IDLE_W[3:0];
    m_hi.delete();
    m_hi.push_back(IDLE_W[7:4]);
  endfunction

  function automatic void model_step();
    bit set_p = train_req && (m_mode != 1);
    logic [7:0] w = IDLE_W;
    bit tr = 0;
    m_und = 0;
    if (!m_phase) begin
      m_data = m_hi.pop_front();
    end else begin
      case (m_mode)
        0: if (m_pend) begin
             w = TRAIN_W; m_mode = 1; m_left = TL - 1; m_pend = 0; set_p = 0; tr = 1;
           end else if (tx_valid) begin
             w = SYNC_W; m_mode = 2;
           end
        1: if (m_left > 0) begin
             w = TRAIN_W; m_left--; tr = 1;
           end else m_mode = 0;
        default: if (m_last) begin
             m_mode = 0; m_last = 0;
           end else if (tx_valid) begin
             w = tx_data; m_last = tx_last;
           end else begin
             m_mode = 0; m_und = 1;
           end
      endcase
      m_data = w[3:0];
      m_hi.push_back(w[7:4]);
      m_train = tr;
    end
    if (set_p) m_pend = 1;
    m_phase = !m_phase;
  endfunction

  task automatic check_outputs();
    check("data", 32'(data), 32'(m_data));
    check("training", 32'(training), 32'(m_train));
    check("underrun", 32'(underrun), 32'(m_und));
  endtask

  task automatic cycle(input bit e, input bit r, input bit v, input logic [7:0] d, input bit l,
                       output bit rdy, output logic [3:0] dout);
    @(negedge clk);
    clk__enable = e; train_req = r; tx_valid = v; tx_data = d; tx_last = l;
    #1;
    rdy = tx_ready;
    check("tx_ready", 32'(tx_ready), 32'(e & m_phase & (m_mode == 2) & !m_last));
    @(posedge clk);
    if (e) model_step();
    #1;
    dout = data;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("tx_ready_rst", 32'(tx_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Sends 11,22,33 as one frame, optionally with a gappy enable, and checks the wire nibbles.
  task automatic frame_123(input bit gappy);
    logic [7:0] bq[$];
    logic [3:0] seen[$];
    logic [3:0] exp3[8];
    bit rdy, e, v;
    logic [3:0] dout;
    exp3 = '{4'h8, 4'hB, 4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3};
    bq = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 40; i++) begin
      e = gappy ? ((i % 3) != 1) : 1'b1;
      v = bq.size() > 0;
      cycle(e, 0, v, v ? bq[0] : 8'h00, bq.size() == 1, rdy, dout);
      if (!e) check("ready_disabled", 32'(rdy), 32'd0);
      if (rdy && v) void'(bq.pop_front());
      if (e && dout != 4'h0) seen.push_back(dout);
    end
    check("frame_nibbles", 32'(seen.size()), 32'd8);
    for (int i = 0; i < 8 && i < seen.size(); i++)
      check("frame_nibble", 32'(seen[i]), 32'(exp3[i]));
  endtask

  initial begin
    bit rdy;
    logic [3:0] dout;
    int tcount;
    clk__enable = 0; reset_n = 0; train_req = 0; tx_valid = 0; tx_data = 0; tx_last = 0;
    model_reset();
    #12;
    check_outputs();
    check("tx_ready_rst", 32'(tx_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) cycle(1, 0, 0, 8'h00, 0, rdy, dout);

    frame_123(0);
    frame_123(1);

    // Training burst: exactly 2*TL enabled cycles with training high.
    tcount = 0;
    cycle(1, 1, 0, 8'h00, 0, rdy, dout);
    for (int i = 0; i < 30; i++) begin
      cycle(1, 0, 0, 8'h00, 0, rdy, dout);
      if (training) tcount++;
    end
    check("train_cycles", 32'(tcount), 32'(2 * TL));

    for (int i = 0; i < 2000; i++) begin
      bit e = (i >= 1500) || ($urandom_range(0, 9) < 8);
      bit r = $urandom_range(0, 39) == 0;
      bit v = $urandom_range(0, 9) < 7;
      bit l = $urandom_range(0, 3) == 0;
      logic [7:0] d = 8'($urandom);
      if (i == 700 || i == 1300) do_reset();
      cycle(e, r, v, d, l, rdy, dout);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
